// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx -- PS/2 keyboard receiver with prefix merging and an event FIFO.
//
// The raw ps2clk/ps2data lines are synchronised, and ps2clk is glitch-filtered.
// The receiver assembles 11-bit frames (start, 8 data bits LSB first, odd
// parity, stop) and aborts a stalled frame after a timeout. Each good byte
// goes to an assembler that folds E0 (extended) and F0 (break) prefixes into
// one make/break event. Events are queued in a first-word fall-through FIFO
// with a valid/ready interface to the consumer.
//
// Optional build macro: PS2_TYPEMATIC_FILTER_EN
//   When defined, a make event is suppressed if it repeats the last pushed
//   make code and no break event has occurred since.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   ps2clk, ps2data raw asynchronous PS/2 lines
//   code            {E0 or 00, scan byte} of the head event (0 when empty)
//   code_break      head event is a key release
//   code_valid      FIFO non-empty
//   code_ready      consumer takes the head event when code_valid=1
//   frame_err       one-cycle pulse on framing/parity/timeout error
//   overflow        one-cycle pulse when an event is dropped on a full FIFO
//   fifo_level      number of occupied FIFO entries
module ps2_scan_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  output logic [15:0]                   code,
  output logic                          code_break,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // ---------------------------------------------------------------- sync
  // Reset to 1 so the idle-high lines never produce a false falling edge.
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   s_clk, s_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2data};
    end
  end

  assign s_clk = clk_sync[SYNC_STAGES-1];
  assign s_dat = dat_sync[SYNC_STAGES-1];

  // -------------------------------------------------------------- filter
  // The filtered clock follows the synced clock only after FILTER_LEN
  // consecutive samples disagree with it. Any agreeing sample restarts the run.
  logic          filt, filt_d;
  logic [FW-1:0] fcnt;
  logic          strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (s_clk == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= s_clk;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign strobe = filt_d & ~filt;

  // ----------------------------------------------------------- frame FSM
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          byte_vld;
  logic [7:0]    byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      par_bit   <= 1'b0;
      tcnt      <= '0;
      byte_vld  <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;

      // The stall timer runs only while a frame is open, and every edge restarts it.
      if (strobe || state == S_IDLE) tcnt <= '0;
      else                           tcnt <= tcnt + 1'b1;

      if (state != S_IDLE && !strobe && tcnt == TW'(TIMEOUT_CYC - 1)) begin
        state     <= S_IDLE;
        frame_err <= 1'b1;
        tcnt      <= '0;
      end else if (strobe) begin
        case (state)
          S_IDLE: begin
            if (!s_dat) begin
              state  <= S_DATA;
              bitcnt <= '0;
            end
          end
          S_DATA: begin
            shreg  <= {s_dat, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= s_dat;
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if ((^{shreg, par_bit}) && s_dat) begin
              byte_vld <= 1'b1;
              byte_q   <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // ----------------------------------------------------------- assembler
  logic        ext, brk;
  logic        ev_vld, ev_brk, suppress, push, pop, full, wr_en;
  logic [15:0] ev_code;

  assign ev_vld  = byte_vld && byte_q != 8'hE0 && byte_q != 8'hF0;
  assign ev_code = {(ext ? 8'hE0 : 8'h00), byte_q};
  assign ev_brk  = brk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (frame_err) begin
      // frame_err is exclusive with byte_vld, so a bad frame always resets the prefixes.
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_vld) begin
      if (byte_q == 8'hE0) begin
        ext <= 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [15:0] last_code;
  logic        last_vld;

  assign suppress = ev_vld && !ev_brk && last_vld && last_code == ev_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_code <= '0;
      last_vld  <= 1'b0;
    end else if (wr_en && !ev_brk) begin
      last_code <= ev_code;
      last_vld  <= 1'b1;
    end else if (ev_vld && ev_brk) begin
      last_vld  <= 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign push       = ev_vld && !suppress;
  assign code_valid = (fifo_level != '0);
  assign pop        = code_valid && code_ready;
  assign full       = (fifo_level == LW'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign wr_en      = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ev_brk, ev_code};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push && !wr_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign code       = code_valid ? mem[rd_ptr][15:0] : 16'h0000;
  assign code_break = code_valid ? mem[rd_ptr][16]   : 1'b0;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx -- directed bench for ps2_scan_rx (TIMEOUT_CYC=200, FIFO_DEPTH=8).
// PS/2 bits are driven with 10 cycles of data setup, 20 cycles of clock low
// and 10 cycles of clock high. Events are taken one at a time with code_ready.
module tb_ps2_scan_rx;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ps2clk = 1'b1, ps2data = 1'b1, code_ready = 1'b0;
  logic [15:0] code;
  logic        code_break, code_valid, frame_err, overflow;
  logic [3:0]  fifo_level;

  int errs = 0, checks = 0, fe_cnt = 0, ov_cnt = 0, fe0, ov0;

  ps2_scan_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(200), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ps2clk(ps2clk), .ps2data(ps2data),
    .code(code), .code_break(code_break), .code_valid(code_valid),
    .code_ready(code_ready), .frame_err(frame_err), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Pulse counters (each pulse is one cycle wide, so cycles high == pulses).
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overflow)  ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One PS/2 bit. With lat=1, check that code_valid is still low at E+1 and high at E+2.
  task automatic ps2_bit(input logic b, input logic lat);
    @(negedge clk); ps2data = b;
    repeat (10) @(negedge clk);
    ps2clk = 1'b0;
    if (lat) begin
      repeat (7) @(negedge clk);
      chk("lat_e1_valid", code_valid, 0);
      @(negedge clk);
      chk("lat_e2_valid", code_valid, 1);
      repeat (12) @(negedge clk);
    end else begin
      repeat (20) @(negedge clk);
    end
    ps2clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par = 1'b0,
                      input logic bad_stop = 1'b0, input logic lat = 1'b0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ bad_par, 1'b0);
    ps2_bit(~bad_stop, lat);
    ps2data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic pop(input string tag, input logic [15:0] c, input logic br);
    @(negedge clk);
    chk({tag, "_valid"}, code_valid, 1);
    chk({tag, "_code"}, code, c);
    chk({tag, "_brk"}, code_break, br);
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", code_valid, 0);
    chk("rst_code", code, 0);
    chk("rst_brk", code_break, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_valid", code_valid, 0);

    // 1: simple make with latency check
    send(8'h1C, 1'b0, 1'b0, 1'b1);
    pop("t1", 16'h001C, 1'b0);
    chk("t1_level", fifo_level, 0);

    // 2: break prefix
    send(8'hF0);
    chk("t2_f0_level", fifo_level, 0);
    send(8'h1C);
    pop("t2", 16'h001C, 1'b1);

    // 3: extended make and break
    send(8'hE0); send(8'h75);
    pop("t3a", 16'hE075, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h75);
    pop("t3b", 16'hE075, 1'b1);

    // 4: parity and stop errors; an error also clears a pending prefix
    fe0 = fe_cnt;
    send(8'h1C, 1'b1);
    chk("t4_par_ferr", fe_cnt - fe0, 1);
    chk("t4_par_level", fifo_level, 0);
    send(8'h32);
    pop("t4a", 16'h0032, 1'b0);
    chk("t4a_level", fifo_level, 0);
    fe0 = fe_cnt;
    send(8'hF0);
    send(8'h4D, 1'b0, 1'b1);
    chk("t4_stop_ferr", fe_cnt - fe0, 1);
    chk("t4_stop_level", fifo_level, 0);
    send(8'h4D);
    pop("t4b", 16'h004D, 1'b0);

    // 5: timeout after start + 4 bits
    fe0 = fe_cnt;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
    ps2data = 1'b1;
    repeat (300) @(negedge clk);
    chk("t5_ferr", fe_cnt - fe0, 1);
    chk("t5_level", fifo_level, 0);
    send(8'h1C);
    pop("t5", 16'h001C, 1'b0);

    // 6: overflow with ready held low
    ov0 = ov_cnt;
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("t6_level", fifo_level, 8);
    chk("t6_ovf", ov_cnt - ov0, 1);
    for (int i = 1; i <= 8; i++) pop("t6", 16'(i), 1'b0);
    chk("t6_empty", fifo_level, 0);
    chk("t6_empty_code", code, 0);

    // 7: typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t7_level", fifo_level, 3);
    pop("t7a", 16'h001C, 1'b0);
    pop("t7b", 16'h001C, 1'b1);
    pop("t7c", 16'h001C, 1'b0);
`else
    chk("t7_level", fifo_level, 5);
    pop("t7a", 16'h001C, 1'b0);
    pop("t7b", 16'h001C, 1'b0);
    pop("t7c", 16'h001C, 1'b0);
    pop("t7d", 16'h001C, 1'b1);
    pop("t7e", 16'h001C, 1'b0);
`endif
    chk("t7_empty", fifo_level, 0);
    chk("t7_ovf", ov_cnt - ov0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
